// File: rtl/pid_limiter_pkg.sv
// Shared definitions for the PID output limiter: register map offsets, bit
// positions inside the ctrl and status registers, and the default sample type.
package pid_limiter_pkg;

  // Default signed sample width on the stream ports and limit registers.
  localparam int SAMPLE_WIDTH = 16;
  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // Register offsets relative to BASE_ADDRESS.
  localparam logic [31:0] OFF_CTRL      = 32'h00;
  localparam logic [31:0] OFF_LIMIT_MAX = 32'h04;
  localparam logic [31:0] OFF_LIMIT_MIN = 32'h08;
  localparam logic [31:0] OFF_RATE_UP   = 32'h0C;
  localparam logic [31:0] OFF_RATE_DOWN = 32'h10;
  localparam logic [31:0] OFF_STATUS    = 32'h14;

  // ctrl bits
  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_RATE_EN = 1;

  // status bits (sticky, write-1-to-clear)
  localparam int ST_SAT_HIGH = 0;
  localparam int ST_SAT_LOW  = 1;
  localparam int ST_RATE_HIT = 2;

endpackage

// File: rtl/pid_output_limiter_if.sv
// Bus interfaces used by the PID output limiter.
//  axi_lite_if   : AXI-lite register port (no wstrb/prot; full-word accesses)
//  axi_stream_if : signed sample stream with valid/ready handshake
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface axi_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] data;
  logic                         valid;
  logic                         ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/pid_limiter_regs.sv
// AXI-lite register file for the PID output limiter.
//  clock, reset  : rising-edge clock, synchronous active-high reset
//  axil          : AXI-lite slave; a write is accepted when awvalid and wvalid
//                  are both high and no response is pending, and the register
//                  updates on the same edge that raises bvalid
//  set_status    : one-cycle set pulses for the sticky status bits
//  enable..      : current configuration, sampled by the datapath per sample
// Limit registers read back sign-extended, rate registers zero-extended.
module pid_limiter_regs
  import pid_limiter_pkg::*;
#(
  parameter int          DATA_WIDTH   = SAMPLE_WIDTH,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic                         clock,
  input  logic                         reset,
  axi_lite_if.slave                    axil,
  input  logic [2:0]                   set_status,
  output logic                         enable,
  output logic                         rate_en,
  output logic signed [DATA_WIDTH-1:0] limit_max,
  output logic signed [DATA_WIDTH-1:0] limit_min,
  output logic [DATA_WIDTH-1:0]        rate_up,
  output logic [DATA_WIDTH-1:0]        rate_down
);

  localparam logic signed [DATA_WIDTH-1:0] MAX_RESET = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_RESET = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]  status;
  logic [2:0]  w1c;
  logic        wr_go;
  logic        rd_go;
  logic [31:0] wr_off;
  logic [31:0] rd_off;
  logic [31:0] rd_word;

  assign wr_go        = axil.awvalid & axil.wvalid & ~axil.bvalid;
  assign rd_go        = axil.arvalid & ~axil.rvalid;
  assign axil.awready = wr_go;
  assign axil.wready  = wr_go;
  assign axil.arready = rd_go;
  assign axil.bresp   = 2'b00;
  assign axil.rresp   = 2'b00;
  assign wr_off       = axil.awaddr - BASE_ADDRESS;
  assign rd_off       = axil.araddr - BASE_ADDRESS;

  always_comb begin
    w1c = '0;
    if (wr_go && wr_off == OFF_STATUS) w1c = axil.wdata[2:0];
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    case (rd_off)
      OFF_CTRL:      rd_word = {30'd0, rate_en, enable};
      OFF_LIMIT_MAX: rd_word = 32'(limit_max);
      OFF_LIMIT_MIN: rd_word = 32'(limit_min);
      OFF_RATE_UP:   rd_word = 32'(rate_up);
      OFF_RATE_DOWN: rd_word = 32'(rate_down);
      OFF_STATUS:    rd_word = {29'd0, status};
      default:       rd_word = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      enable      <= 1'b0;
      rate_en     <= 1'b0;
      limit_max   <= MAX_RESET;
      limit_min   <= MIN_RESET;
      rate_up     <= '0;
      rate_down   <= '0;
      status      <= '0;
      axil.bvalid <= 1'b0;
      axil.rvalid <= 1'b0;
      axil.rdata  <= '0;
    end else begin
      // A new event in the same cycle as a clear keeps the bit set.
      status <= (status & ~w1c) | set_status;

      if (wr_go) begin
        axil.bvalid <= 1'b1;
        case (wr_off)
          OFF_CTRL: begin
            enable  <= axil.wdata[CTRL_ENABLE];
            rate_en <= axil.wdata[CTRL_RATE_EN];
          end
          OFF_LIMIT_MAX: limit_max <= axil.wdata[DATA_WIDTH-1:0];
          OFF_LIMIT_MIN: limit_min <= axil.wdata[DATA_WIDTH-1:0];
          OFF_RATE_UP:   rate_up   <= axil.wdata[DATA_WIDTH-1:0];
          OFF_RATE_DOWN: rate_down <= axil.wdata[DATA_WIDTH-1:0];
          default: ;
        endcase
      end else if (axil.bready) begin
        axil.bvalid <= 1'b0;
      end

      if (rd_go) begin
        axil.rvalid <= 1'b1;
        axil.rdata  <= rd_word;
      end else if (axil.rready) begin
        axil.rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pid_output_limiter.sv
// PID output limiter: clamps each PID output sample to [limit_min, limit_max]
// (stage 1), then slew-limits it against the last emitted sample (stage 2).
//  clock, reset : rising-edge clock, synchronous active-high reset
//  axil         : AXI-lite slave for configuration and sticky status
//  in           : signed sample stream from the PID
//  out          : limited sample stream to the modulator
//  saturation   : {sat_high, sat_low} of the sample currently on out
// Both stages advance together whenever the output stage is empty or being
// consumed. Each sample carries its own copy of the configuration.
module pid_output_limiter
  import pid_limiter_pkg::*;
#(
  parameter int          DATA_WIDTH   = SAMPLE_WIDTH,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic         clock,
  input  logic         reset,
  axi_lite_if.slave    axil,
  axi_stream_if.slave  in,
  axi_stream_if.master out,
  output logic [1:0]   saturation
);

  localparam int DW = DATA_WIDTH;
  typedef logic signed [DW-1:0] smp_t;
  typedef logic signed [DW:0]   wide_t;

  logic          enable, rate_en;
  smp_t          limit_max, limit_min;
  logic [DW-1:0] rate_up, rate_down;
  logic [2:0]    set_status;

  pid_limiter_regs #(.DATA_WIDTH(DW), .BASE_ADDRESS(BASE_ADDRESS)) u_regs (
    .clock      (clock),
    .reset      (reset),
    .axil       (axil),
    .set_status (set_status),
    .enable     (enable),
    .rate_en    (rate_en),
    .limit_max  (limit_max),
    .limit_min  (limit_min),
    .rate_up    (rate_up),
    .rate_down  (rate_down)
  );

  logic          advance, in_fire, out_fire;
  logic          s1_valid, s1_rate_active;
  smp_t          s1_data;
  logic [1:0]    s1_sat;
  logic [DW-1:0] s1_rate_up, s1_rate_down;
  logic          s2_valid;
  smp_t          s2_data;
  logic [1:0]    s2_sat;
  smp_t          prev;
  logic          primed;

  assign advance    = !s2_valid || out.ready;
  assign in.ready   = !reset && advance;
  assign in_fire    = in.valid && in.ready;
  assign out_fire   = s2_valid && out.ready;
  assign out.valid  = s2_valid;
  assign out.data   = s2_data;
  assign saturation = s2_sat;

  // Stage 1: upper clip first, then lower clip on its result, so inverted
  // limits always resolve to limit_min with only sat_low reported.
  smp_t hi_clip, clamped;
  logic sat_hi, sat_lo;

  always_comb begin
    hi_clip = in.data;
    clamped = in.data;
    sat_hi  = 1'b0;
    sat_lo  = 1'b0;
    if (enable) begin
      sat_hi  = in.data > limit_max;
      hi_clip = sat_hi ? limit_max : in.data;
      sat_lo  = hi_clip < limit_min;
      clamped = sat_lo ? limit_min : hi_clip;
      if (sat_lo) sat_hi = 1'b0;
    end
  end

  // Stage 2: the reference is the last emitted sample. When the sample in
  // stage 2 leaves on this very edge it is the reference, not the old prev.
  smp_t  prev_eff, s2_next;
  logic  primed_eff, rate_hit;
  wide_t delta, up_lim, dn_lim, limited;

  always_comb begin
    prev_eff   = out_fire ? s2_data : prev;
    primed_eff = primed || out_fire;
    delta      = wide_t'(s1_data) - wide_t'(prev_eff);
    up_lim     = wide_t'({1'b0, s1_rate_up});
    dn_lim     = -wide_t'({1'b0, s1_rate_down});
    limited    = wide_t'(s1_data);
    rate_hit   = 1'b0;
    if (s1_rate_active && primed_eff) begin
      if (delta > up_lim) begin
        limited  = wide_t'(prev_eff) + up_lim;
        rate_hit = 1'b1;
      end else if (delta < dn_lim) begin
        limited  = wide_t'(prev_eff) + dn_lim;
        rate_hit = 1'b1;
      end
    end
    // The limited value lies between prev and the clamped sample, so it fits.
    s2_next = limited[DW-1:0];
  end

  assign set_status[ST_SAT_HIGH] = in_fire && sat_hi;
  assign set_status[ST_SAT_LOW]  = in_fire && sat_lo;
  assign set_status[ST_RATE_HIT] = advance && s1_valid && rate_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      s1_sat         <= '0;
      s1_rate_active <= 1'b0;
      s1_rate_up     <= '0;
      s1_rate_down   <= '0;
      s2_valid       <= 1'b0;
      s2_data        <= '0;
      s2_sat         <= '0;
      prev           <= '0;
      primed         <= 1'b0;
    end else begin
      if (out_fire) begin
        prev   <= s2_data;
        primed <= 1'b1;
      end
      if (advance) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_data        <= clamped;
          s1_sat         <= {sat_hi, sat_lo};
          s1_rate_active <= enable && rate_en;
          s1_rate_up     <= rate_up;
          s1_rate_down   <= rate_down;
        end
        s2_valid <= s1_valid;
        s2_sat   <= s1_valid ? s1_sat : 2'b00;
        if (s1_valid) s2_data <= s2_next;
      end
    end
  end

endmodule

// File: tb/tb_pid_output_limiter.sv
// Directed testbench for pid_output_limiter.
module tb_pid_output_limiter;
  import pid_limiter_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] saturation;
  int         check_count = 0;
  int         pass_count  = 0;

  axi_lite_if                  axil ();
  axi_stream_if #(.DATA_WIDTH(SAMPLE_WIDTH)) s_in ();
  axi_stream_if #(.DATA_WIDTH(SAMPLE_WIDTH)) s_out ();

  pid_output_limiter #(.DATA_WIDTH(SAMPLE_WIDTH), .BASE_ADDRESS(BASE)) dut (
    .clock      (clock),
    .reset      (reset),
    .axil       (axil),
    .in         (s_in),
    .out        (s_out),
    .saturation (saturation)
  );

  always #5 clock = ~clock;

  sample_t    tx_q[$];
  sample_t    rx_data[$];
  logic [1:0] rx_sat[$];
  int         first_in_cyc, first_out_cyc;

  // ---------------- stimulus helpers ----------------
  task automatic axil_write(input logic [31:0] off, input logic [31:0] data);
    int n = 0;
    @(negedge clock);
    axil.awaddr = BASE + off; axil.wdata = data;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b1;
    #1;
    while (!axil.awready && n < 20) begin @(negedge clock); #1; n++; end
    if (n >= 20) begin check_count++; $display("FAIL axil_write_accept: no awready for offset %h", off); end
    @(posedge clock); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    n = 0;
    while (!axil.bvalid && n < 20) begin @(posedge clock); #1; n++; end
    if (n >= 20) begin check_count++; $display("FAIL axil_write_resp: no bvalid for offset %h", off); end
    @(posedge clock); #1;
    axil.bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] off, output logic [31:0] data);
    int n = 0;
    @(negedge clock);
    axil.araddr = BASE + off; axil.arvalid = 1'b1; axil.rready = 1'b1;
    #1;
    while (!axil.arready && n < 20) begin @(negedge clock); #1; n++; end
    if (n >= 20) begin check_count++; $display("FAIL axil_read_accept: no arready for offset %h", off); end
    @(posedge clock); #1;
    axil.arvalid = 1'b0;
    n = 0;
    while (!axil.rvalid && n < 20) begin @(posedge clock); #1; n++; end
    if (n >= 20) begin check_count++; $display("FAIL axil_read_resp: no rvalid for offset %h", off); end
    data = axil.rdata;
    @(posedge clock); #1;
    axil.rready = 1'b0;
  endtask

  // Sends tx_q back-to-back with out.ready held high and collects outputs.
  task automatic pump(input int exp_count);
    int sent = 0;
    int n = 0;
    rx_data.delete(); rx_sat.delete();
    first_in_cyc = -1; first_out_cyc = -1;
    s_out.ready = 1'b1;
    while (rx_data.size() < exp_count && n < 100) begin
      @(negedge clock);
      s_in.valid = (sent < tx_q.size());
      s_in.data  = s_in.valid ? tx_q[sent] : '0;
      #1;
      if (s_in.valid && s_in.ready) begin
        if (first_in_cyc < 0) first_in_cyc = n;
        sent++;
      end
      if (s_out.valid && s_out.ready) begin
        if (first_out_cyc < 0) first_out_cyc = n;
        rx_data.push_back(s_out.data);
        rx_sat.push_back(saturation);
      end
      n++;
    end
    @(posedge clock); #1;
    s_in.valid = 1'b0;
    tx_q.delete();
    if (rx_data.size() < exp_count) begin
      check_count++;
      $display("FAIL pump_timeout: got %0d outputs, required %0d", rx_data.size(), exp_count);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; s_in.valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] offs[6] = '{OFF_CTRL, OFF_LIMIT_MAX, OFF_LIMIT_MIN, OFF_RATE_UP, OFF_RATE_DOWN, OFF_STATUS};
    logic [31:0] exps[6] = '{32'h0, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0, 32'h0, 32'h0};
    logic [31:0] rd;
    reset = 1'b1;
    s_out.ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_count++;
    if (s_out.valid !== 1'b0 || s_out.data !== 16'sd0) $display("FAIL reset_out: valid %b data %0d, required 0/0", s_out.valid, s_out.data);
    else pass_count++;
    check_count++;
    if (saturation !== 2'b00) $display("FAIL reset_saturation: got %b required 00", saturation);
    else pass_count++;
    check_count++;
    if (s_in.ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", s_in.ready);
    else pass_count++;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      axil_read(offs[i], rd);
      check_count++;
      if (rd !== exps[i]) $display("FAIL reset_reg_%h: got %h required %h", offs[i], rd, exps[i]);
      else pass_count++;
    end
  endtask

  task automatic test_clamp();
    sample_t    exp_d[3] = '{16'sd500, 16'sd1000, -16'sd1000};
    logic [1:0] exp_s[3] = '{2'b00, 2'b10, 2'b01};
    logic [31:0] rd;
    axil_write(OFF_LIMIT_MAX, 32'd1000);
    axil_write(OFF_LIMIT_MIN, 32'hFFFF_FC18);
    axil_write(OFF_CTRL, 32'h1);
    tx_q = '{16'sd500, 16'sd1500, -16'sd2000};
    pump(3);
    for (int i = 0; i < 3; i++) begin
      check_count++;
      if (rx_data[i] !== exp_d[i] || rx_sat[i] !== exp_s[i])
        $display("FAIL clamp_%0d: got data %0d sat %b, required data %0d sat %b", i, rx_data[i], rx_sat[i], exp_d[i], exp_s[i]);
      else pass_count++;
    end
    axil_read(OFF_STATUS, rd);
    check_count++;
    if (rd !== 32'h3) $display("FAIL clamp_status: got %h required 3", rd);
    else pass_count++;
  endtask

  task automatic test_rate();
    sample_t exp_a[5] = '{16'sd0, 16'sd100, 16'sd200, 16'sd300, 16'sd400};
    sample_t exp_b[2] = '{16'sd350, 16'sd300};
    logic [31:0] rd;
    apply_reset();
    axil_write(OFF_RATE_UP, 32'd100);
    axil_write(OFF_RATE_DOWN, 32'd50);
    axil_write(OFF_CTRL, 32'h3);
    tx_q = '{16'sd0, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000};
    pump(5);
    for (int i = 0; i < 5; i++) begin
      check_count++;
      if (rx_data[i] !== exp_a[i]) $display("FAIL rate_up_%0d: got %0d required %0d", i, rx_data[i], exp_a[i]);
      else pass_count++;
    end
    axil_read(OFF_STATUS, rd);
    check_count++;
    if (rd !== 32'h4) $display("FAIL rate_status: got %h required 4", rd);
    else pass_count++;
    tx_q = '{16'sd0, 16'sd0};
    pump(2);
    for (int i = 0; i < 2; i++) begin
      check_count++;
      if (rx_data[i] !== exp_b[i]) $display("FAIL rate_down_%0d: got %0d required %0d", i, rx_data[i], exp_b[i]);
      else pass_count++;
    end
  endtask

  task automatic test_back_to_back();
    sample_t ramp[8];
    sample_t held = '0;
    logic    stalled = 1'b0;
    int      sent = 0, recv = 0, n = 0;
    for (int i = 0; i < 8; i++) ramp[i] = sample_t'(i * 100 - 300);
    axil_write(OFF_CTRL, 32'h1);
    while (recv < 8 && n < 200) begin
      @(negedge clock);
      s_in.valid  = (sent < 8);
      s_in.data   = (sent < 8) ? ramp[sent] : '0;
      s_out.ready = (n % 3 == 2);
      #1;
      if (stalled) begin
        check_count++;
        if (s_out.valid !== 1'b1 || s_out.data !== held)
          $display("FAIL stall_hold: got valid %b data %0d, required 1 / %0d", s_out.valid, s_out.data, held);
        else pass_count++;
      end
      stalled = s_out.valid && !s_out.ready;
      held    = s_out.data;
      if (s_in.valid && s_in.ready) sent++;
      if (s_out.valid && s_out.ready) begin
        check_count++;
        if (s_out.data !== ramp[recv]) $display("FAIL stall_order_%0d: got %0d required %0d", recv, s_out.data, ramp[recv]);
        else pass_count++;
        recv++;
      end
      n++;
    end
    @(posedge clock); #1;
    s_in.valid = 1'b0; s_out.ready = 1'b1;
    check_count++;
    if (recv < 8) $display("FAIL stall_timeout: got %0d outputs required 8", recv);
    else if (s_out.valid !== 1'b0) $display("FAIL stall_extra: out.valid %b after last sample, required 0", s_out.valid);
    else pass_count++;
  endtask

  task automatic test_limits_inverted();
    axil_write(OFF_LIMIT_MIN, 32'd200);
    axil_write(OFF_LIMIT_MAX, 32'd100);
    tx_q = '{16'sd150};
    pump(1);
    check_count++;
    if (rx_data[0] !== 16'sd200 || rx_sat[0] !== 2'b01)
      $display("FAIL inverted_limits: got data %0d sat %b, required 200 sat 01", rx_data[0], rx_sat[0]);
    else pass_count++;
    axil_write(OFF_CTRL, 32'h0);
    tx_q = '{16'sd30000};
    pump(1);
    check_count++;
    if (rx_data[0] !== 16'sd30000 || rx_sat[0] !== 2'b00)
      $display("FAIL bypass_value: got data %0d sat %b, required 30000 sat 00", rx_data[0], rx_sat[0]);
    else pass_count++;
    check_count++;
    if (first_out_cyc - first_in_cyc !== 2) $display("FAIL bypass_latency: got %0d cycles required 2", first_out_cyc - first_in_cyc);
    else pass_count++;
  endtask

  task automatic test_reset_flush();
    logic [31:0] offs[6] = '{OFF_CTRL, OFF_LIMIT_MAX, OFF_LIMIT_MIN, OFF_RATE_UP, OFF_RATE_DOWN, OFF_STATUS};
    logic [31:0] exps[6] = '{32'h0, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0, 32'h0, 32'h0};
    logic [31:0] rd;
    axil_write(OFF_CTRL, 32'h1);
    s_out.ready = 1'b0;
    @(negedge clock); s_in.valid = 1'b1; s_in.data = 16'sd11;
    @(negedge clock); s_in.data = 16'sd22;
    @(negedge clock); s_in.valid = 1'b0;
    #1;
    check_count++;
    if (s_out.valid !== 1'b1) $display("FAIL flush_inflight: out.valid %b required 1", s_out.valid);
    else pass_count++;
    reset = 1'b1;
    @(negedge clock); #1;
    check_count++;
    if (s_out.valid !== 1'b0 || s_in.ready !== 1'b0)
      $display("FAIL flush_reset: out.valid %b in.ready %b, required 0/0", s_out.valid, s_in.ready);
    else pass_count++;
    reset = 1'b0;
    s_out.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      axil_read(offs[i], rd);
      check_count++;
      if (rd !== exps[i]) $display("FAIL flush_reg_%h: got %h required %h", offs[i], rd, exps[i]);
      else pass_count++;
    end
    axil_write(OFF_RATE_UP, 32'd1);
    axil_write(OFF_RATE_DOWN, 32'd1);
    axil_write(OFF_CTRL, 32'h3);
    tx_q = '{16'sd5000, -16'sd5000};
    pump(2);
    check_count++;
    if (rx_data[0] !== 16'sd5000) $display("FAIL unprimed_pass: got %0d required 5000", rx_data[0]);
    else pass_count++;
    check_count++;
    if (rx_data[1] !== 16'sd4999) $display("FAIL primed_limit: got %0d required 4999", rx_data[1]);
    else pass_count++;
  endtask

  task automatic test_w1c();
    logic [31:0] rd;
    apply_reset();
    axil_write(OFF_LIMIT_MAX, 32'd100);
    axil_write(OFF_CTRL, 32'h1);
    tx_q = '{16'sd500};
    pump(1);
    check_count++;
    if (rx_data[0] !== 16'sd100 || rx_sat[0] !== 2'b10)
      $display("FAIL w1c_first: got data %0d sat %b, required 100 sat 10", rx_data[0], rx_sat[0]);
    else pass_count++;
    axil_read(OFF_STATUS, rd);
    check_count++;
    if (rd !== 32'h1) $display("FAIL w1c_before: status %h required 1", rd);
    else pass_count++;
    // Clear request and a new sat_high sample land on the same edge.
    @(negedge clock);
    axil.awaddr = BASE + OFF_STATUS; axil.wdata = 32'h1;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b1;
    s_in.valid = 1'b1; s_in.data = 16'sd600; s_out.ready = 1'b1;
    #1;
    check_count++;
    if (axil.awready !== 1'b1 || s_in.ready !== 1'b1)
      $display("FAIL w1c_same_edge: awready %b in.ready %b, required 1/1", axil.awready, s_in.ready);
    else pass_count++;
    @(posedge clock); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; s_in.valid = 1'b0;
    @(posedge clock); #1;
    axil.bready = 1'b0;
    check_count++;
    if (s_out.valid !== 1'b1 || s_out.data !== 16'sd100 || saturation !== 2'b10)
      $display("FAIL w1c_sample: valid %b data %0d sat %b, required 1/100/10", s_out.valid, s_out.data, saturation);
    else pass_count++;
    @(posedge clock); #1;
    axil_read(OFF_STATUS, rd);
    check_count++;
    if (rd !== 32'h1) $display("FAIL w1c_set_wins: status %h required 1", rd);
    else pass_count++;
    axil_write(OFF_STATUS, 32'h7);
    axil_read(OFF_STATUS, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL w1c_clear: status %h required 0", rd);
    else pass_count++;
  endtask

  initial begin
    reset = 1'b1;
    axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    s_in.valid = 1'b0; s_in.data = '0; s_out.ready = 1'b0;
    test_reset();
    test_clamp();
    test_rate();
    test_back_to_back();
    test_limits_inverted();
    test_reset_flush();
    test_w1c();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
